// File: rtl/da_fir_pkg.sv
// ---------------------------------------------------------------------------
// da_fir_pkg
// Constants and types shared by the distributed-arithmetic FIR datapath:
// sample/coefficient widths, tap count, and the serializer state encoding.
// ---------------------------------------------------------------------------
package da_fir_pkg;

    localparam int NB_DATA_IN  = 8;   // S(8.7) input sample
    localparam int NB_COEFF    = 8;   // coefficient width
    localparam int N_COEFFS    = 9;   // number of taps
    localparam int NB_DATA_OUT = NB_DATA_IN + NB_COEFF + $clog2(N_COEFFS);

    typedef enum logic {
        IDLE  = 1'b0,   // shift register empty
        SHIFT = 1'b1    // a word is being emitted
    } ser_state_t;

endpackage

// File: rtl/da_fir_bit_serializer.sv
// ---------------------------------------------------------------------------
// da_fir_bit_serializer
// Parallel-to-serial front end for the DA FIR. Accepts one signed sample per
// valid/ready handshake and emits it LSB first, one bit per unpaused clock,
// with a bit-enable strobe and a flag on the sign (last) bit. A one-word hold
// register lets consecutive words stream with no idle cycle between them.
//
// Ports:
//   clock     system clock, rising edge
//   i_reset   asynchronous active-low reset
//   i_data    parallel sample, two's complement
//   i_valid   i_data valid
//   o_ready   a word can be accepted this cycle (hold register empty)
//   i_pause   freeze serialization while high
//   o_bit     serial data bit, LSB first
//   o_enable  o_bit valid (filter enable)
//   o_last    high with the MSB (sign) bit of each word
//   o_busy    a word is in the shift register or the hold register
// ---------------------------------------------------------------------------
module da_fir_bit_serializer
    import da_fir_pkg::*;
#(
    parameter  int NB_DATA_IN = da_fir_pkg::NB_DATA_IN,
    localparam int NB_COUNTER = $clog2(NB_DATA_IN)
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic [NB_DATA_IN-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_pause,
    output logic                  o_bit,
    output logic                  o_enable,
    output logic                  o_last,
    output logic                  o_busy
);

    localparam logic [NB_COUNTER-1:0] LAST_BIT = NB_COUNTER'(NB_DATA_IN - 1);

    ser_state_t              state;
    logic [NB_DATA_IN-1:0]   shift_reg;
    logic [NB_DATA_IN-1:0]   hold_reg;
    logic                    hold_valid;
    logic [NB_COUNTER-1:0]   counter;

    logic                    transfer;
    logic                    load_point;

    // Ready depends only on the hold register, never on i_valid.
    assign o_ready  = !hold_valid;
    assign o_busy   = (state == SHIFT) || hold_valid;
    assign transfer = i_valid && o_ready;

    // A new word may enter the shift register when it is empty, or in the
    // same cycle its last bit is emitted (gives gap-free back-to-back words).
    always_comb begin
        load_point = (state == IDLE) ||
                     ((state == SHIFT) && (counter == LAST_BIT) && !i_pause);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            counter    <= '0;
            o_bit      <= 1'b0;
            o_enable   <= 1'b0;
            o_last     <= 1'b0;
        end else begin
            // Emit one bit per unpaused SHIFT cycle; o_bit holds otherwise.
            if ((state == SHIFT) && !i_pause) begin
                o_bit     <= shift_reg[0];
                o_enable  <= 1'b1;
                o_last    <= (counter == LAST_BIT);
                shift_reg <= shift_reg >> 1;
                counter   <= counter + 1'b1;
            end else begin
                o_enable  <= 1'b0;
                o_last    <= 1'b0;
            end

            // A load overrides the shift above; the hold word has priority
            // over a bypass (no transfer can occur while hold_valid is set).
            if (load_point) begin
                if (hold_valid) begin
                    shift_reg  <= hold_reg;
                    hold_valid <= 1'b0;
                    counter    <= '0;
                    state      <= SHIFT;
                end else if (transfer) begin
                    shift_reg  <= i_data;
                    counter    <= '0;
                    state      <= SHIFT;
                end else begin
                    state      <= IDLE;
                end
            end else if (transfer) begin
                hold_reg   <= i_data;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_da_fir_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_da_fir_bit_serializer
// Self-checking bench: every accepted word is appended (LSB first) to an
// expected bit stream; each enabled output bit must be the next bit of that
// stream, with o_last on every eighth bit. Directed cases cover latency,
// back-to-back streaming, hold-full back-pressure, pause and mid-word reset,
// followed by a randomized valid/pause run.
// ---------------------------------------------------------------------------
module tb_da_fir_bit_serializer;

    localparam int NB = 8;

    logic          clock;
    logic          i_reset;
    logic [NB-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic          i_pause;
    logic          o_bit;
    logic          o_enable;
    logic          o_last;
    logic          o_busy;

    int unsigned   n_total = 0;
    int unsigned   n_bad   = 0;

    da_fir_bit_serializer #(.NB_DATA_IN(NB)) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_pause  (i_pause),
        .o_bit    (o_bit),
        .o_enable (o_enable),
        .o_last   (o_last),
        .o_busy   (o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: expected serial stream -------------
    logic        exp_q[$];
    int unsigned bit_pos   = 0;   // position within current output word
    int unsigned cyc       = 0;   // negedge counter
    int unsigned first_cyc = 0;
    int unsigned last_span = 0;   // cycles from bit 0 to bit 7 of last word
    int unsigned run_len   = 0;
    int unsigned max_run   = 0;

    // Every handshake appends the whole word, LSB first.
    always @(posedge clock) begin
        if (i_reset && i_valid && o_ready) begin
            for (int i = 0; i < NB; i++) exp_q.push_back(i_data[i]);
        end
    end

    always @(negedge clock) begin
        logic b;
        cyc++;
        if (o_enable) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                check_val("spurious_enable", 32'(o_enable), 32'(0));
            end else begin
                b = exp_q.pop_front();
                check_val("bit", 32'(o_bit), 32'(b));
                check_val("last", 32'(o_last), 32'(bit_pos == NB - 1));
                if (bit_pos == 0) first_cyc = cyc;
                if (bit_pos == NB - 1) last_span = cyc - first_cyc;
                bit_pos = (bit_pos + 1) % NB;
            end
        end else begin
            run_len = 0;
            check_val("last_without_enable", 32'(o_last), 32'(0));
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ---------------
    task automatic put_word(input logic [NB-1:0] d);
        int unsigned guard = 0;
        i_data  = d;
        i_valid = 1'b1;
        while (!o_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (!o_ready) check_val("ready_timeout", 32'(o_ready), 32'(1));
        @(negedge clock);          // handshake at the intervening rising edge
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while ((o_busy || o_enable) && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        check_val("drain_timeout", 32'(guard < 300), 32'(1));
        check_val("stream_empty", 32'(exp_q.size()), 32'(0));
        check_val("idle_enable", 32'(o_enable), 32'(0));
        check_val("idle_busy", 32'(o_busy), 32'(0));
    endtask

    initial begin
        logic [NB-1:0] d;
        logic          will_xfer;

        i_reset = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        i_pause = 1'b0;
        repeat (3) @(negedge clock);

        check_val("rst_bit", 32'(o_bit), 32'(0));
        check_val("rst_enable", 32'(o_enable), 32'(0));
        check_val("rst_last", 32'(o_last), 32'(0));
        check_val("rst_busy", 32'(o_busy), 32'(0));
        i_reset = 1'b1;
        @(negedge clock);
        check_val("rst_ready", 32'(o_ready), 32'(1));

        // Single word: first bit appears one cycle after the handshake.
        put_word(8'hA5);
        check_val("latency_not_yet", 32'(o_enable), 32'(0));
        check_val("busy_loaded", 32'(o_busy), 32'(1));
        @(negedge clock);
        check_val("latency_first", 32'(o_enable), 32'(1));
        check_val("first_bit_a5", 32'(o_bit), 32'(1));
        drain();
        check_val("span_a5", 32'(last_span), 32'(NB - 1));

        // Back-to-back: 16 enabled bits with no gap.
        max_run = 0;
        put_word(8'h80);
        put_word(8'h7F);
        drain();
        check_val("b2b_run", 32'(max_run), 32'(2 * NB));

        // Hold full: ready drops after word 2, returns after its load point.
        put_word(8'h01);
        put_word(8'h02);
        check_val("hold_full_ready", 32'(o_ready), 32'(0));
        repeat (6) @(negedge clock);
        check_val("hold_still_full", 32'(o_ready), 32'(0));
        @(negedge clock);
        check_val("hold_released", 32'(o_ready), 32'(1));
        put_word(8'h03);
        drain();

        // Pause for 3 cycles after bit 3: word spans 8 + 3 cycles.
        put_word(8'hC3);
        repeat (4) @(negedge clock);
        i_pause = 1'b1;
        repeat (3) @(negedge clock);
        i_pause = 1'b0;
        drain();
        check_val("pause_span", 32'(last_span), 32'(NB - 1 + 3));

        // Reset after bit 4 of 8'hFF with 8'h0F held: both words dropped.
        put_word(8'hFF);
        put_word(8'h0F);
        repeat (4) @(negedge clock);
        #2 i_reset = 1'b0;
        #1;
        check_val("midrst_enable", 32'(o_enable), 32'(0));
        check_val("midrst_bit", 32'(o_bit), 32'(0));
        check_val("midrst_last", 32'(o_last), 32'(0));
        check_val("midrst_busy", 32'(o_busy), 32'(0));
        exp_q.delete();
        bit_pos = 0;
        @(negedge clock);
        i_reset = 1'b1;
        @(negedge clock);
        check_val("midrst_ready", 32'(o_ready), 32'(1));
        put_word(8'h55);
        drain();

        // Randomized valid/data/pause traffic against the stream model.
        will_xfer = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (!i_valid || will_xfer) begin
                d       = NB'($urandom);
                i_data  = d;
                i_valid = ($urandom_range(0, 2) != 0);
            end
            i_pause   = ($urandom_range(0, 4) == 0);
            will_xfer = i_valid && o_ready;
        end
        @(negedge clock);
        i_valid = 1'b0;
        i_pause = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/da_fir_bit_serializer.md
Name: da_fir_bit_serializer

Overview:
- Parallel-to-serial front end for the distributed-arithmetic FIR datapath.
- Accepts signed S(8.7) samples over a valid/ready handshake. Emits each sample one bit per clock, LSB first, together with a bit-enable strobe and a word-boundary flag.
- Its outputs drive the filter's serial data input and enable directly.
- A one-word hold register lets consecutive samples stream with no idle cycle between words.

Parameters:
- NB_DATA_IN, 8, bits per sample; also the number of serial bits per word.
- NB_COUNTER, $clog2(NB_DATA_IN), width of the bit-position counter (derived, not overridden).

Ports:
- clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous active-low reset.
- i_data  input  NB_DATA_IN  parallel sample, two's complement.
- i_valid  input  1  i_data valid.
- o_ready  output  1  block can accept a word this cycle.
- i_pause  input  1  freeze serialization while high.
- o_bit  output  1  serial data bit, LSB first.
- o_enable  output  1  o_bit valid; connects to filter enable.
- o_last  output  1  high with the MSB (sign) bit of each word.
- o_busy  output  1  a word is in the shift register or the hold register.

Behaviour:
- Clock and reset: one clock `clock`. Reset `i_reset` is asynchronous and active-low.
- Reset values:
  - o_bit=0, o_enable=0, o_last=0, o_busy=0.
  - Shift register, hold register, hold_valid and bit counter all cleared.
  - State=IDLE.
  - o_ready=1 once reset deasserts.
- Handshake:
  - Transfer occurs when i_valid && o_ready at a rising edge.
  - o_ready = !hold_valid, combinational from a register only; no dependence on i_valid.
  - i_data must stay stable while i_valid is high and o_ready is low.
- States:
  - IDLE: shift register empty.
  - SHIFT: a word is being emitted.
- Load point: occurs when state==IDLE, or state==SHIFT && counter==NB_DATA_IN-1 && !i_pause.
  - Source is the hold register if hold_valid; hold_valid then clears.
  - Otherwise the source is i_data, if a transfer occurs this cycle (bypass, no hold).
  - Otherwise no load: SHIFT goes to IDLE, or IDLE stays IDLE.
  - A load sets state=SHIFT and counter=0.
- Transfer not at a load point: the word goes to the hold register and hold_valid is set.
- Registered outputs:
  - o_bit=shift[0], o_enable=1, o_last=(counter==NB_DATA_IN-1) during each SHIFT cycle with !i_pause.
  - Each such cycle the shift register shifts right and the counter increments.
- Latency: a word accepted at edge T from IDLE with the hold register empty has its bit 0 on o_bit/o_enable after edge T+1. Bits 1..NB_DATA_IN-1 follow on consecutive unpaused cycles.
- Back-to-back: a word loaded at the last-bit load point continues with no gap; o_enable stays high across the word boundary.
- i_pause:
  - While high: o_enable=0, o_last=0; counter, shift register and o_bit hold.
  - Transfers into an empty hold register are still allowed.
  - Resumes at the same bit position.
- Filter alignment: the downstream filter counts only enabled bits, so pauses and gaps keep word alignment. o_enable must never be high outside SHIFT.
- o_busy = (state==SHIFT) || hold_valid.
- Reset mid-word: the partial word and the hold word are discarded; all outputs return to reset values immediately (asynchronous).
- The block does no arithmetic. The word is passed bit-exact; the sign bit is sent last, flagged by o_last.

Decomposition:
- Shared package da_fir_pkg:
  - NB_DATA_IN, NB_COEFF, NB_DATA_OUT and N_COEFFS constants shared with the filter.
  - Two-state encoding (IDLE=1'b0, SHIFT=1'b1).
- No sub-module. Hold register, shift register and counter sit in one always block plus combinational load-select logic (~150 lines).

Test Plan:
- Single word: i_data=8'hA5 accepted from IDLE → after one cycle, o_bit=1,0,1,0,0,1,0,1 on 8 cycles with o_enable=1. o_last=1 only on the 8th bit. Then o_enable=0, o_busy=0.
- Back-to-back: 8'h80 then 8'h7F presented continuously → o_enable high for 16 consecutive cycles. Bits are 0000000 1 1111111 0. o_last is high at cycles 8 and 16.
- Hold full: three words 8'h01, 8'h02, 8'h03 presented back-to-back.
  - o_ready drops after the second is accepted.
  - o_ready rises in the cycle after the load point of word 2.
  - The output stream order is 01, 02, 03.
- Pause: 8'hC3, i_pause high for 3 cycles after bit 3 → o_enable low for exactly 3 cycles. The full sequence 1,1,0,0,0,0,1,1 is preserved.
- Reset mid-word: assert i_reset after bit 4 of 8'hFF with 8'h0F in the hold register → outputs are 0 immediately and o_ready=1 after release. The next word 8'h55 serializes correctly from bit 0.
- End-to-end: drive the serializer into the DA FIR with a 0x7F impulse followed by zeros → filter output matches the 9-tap coefficient sequence scaled by 0x7F.
